// File: rtl/sum_accum_pkg.sv
// Shared Q7.8 configuration for the RBM datapath blocks: word width, saturation
// limits and the sum accumulator state encoding.
package sum_accum_pkg;

    localparam int unsigned Q_W = 16;

    localparam logic [Q_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [Q_W-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Sign-extend a Q7.8 word into a wider accumulator.
    function automatic logic [63:0] sext_q(input logic [Q_W-1:0] x);
        return {{(64-Q_W){x[Q_W-1]}}, x};
    endfunction

endpackage

// File: rtl/sat16.sv
// Clamp a wide signed accumulator value to a signed Q7.8 word.
module sat16
    import sum_accum_pkg::*;
#(
    parameter int unsigned ACC_W = 19
) (
    input  logic [ACC_W-1:0] value,
    output logic [Q_W-1:0]   sat_c
);

    localparam int unsigned HI_W = ACC_W - Q_W + 1;

    logic [HI_W-1:0] hi_c;

    assign hi_c = value[ACC_W-1:Q_W-1];

    // In range only when every bit above the Q7.8 sign bit copies that sign bit.
    always_comb begin
        sat_c = value[Q_W-1:0];
        if ((hi_c != {HI_W{1'b0}}) && (hi_c != {HI_W{1'b1}})) begin
            sat_c = value[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/sum_accum.sv
// Accumulates bias plus the weights of active visible units over N_IN beats and
// presents the saturated Q7.8 sum to the sigmoid stage.
module sum_accum
    import sum_accum_pkg::*;
#(
    parameter int unsigned N_IN  = 16,
    parameter int unsigned CNT_W = $clog2(N_IN)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [Q_W-1:0] bias,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           v_bit,
    input  logic [Q_W-1:0] weight,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Q_W-1:0] sum,
    output logic           busy
);

    localparam int unsigned ACC_W = Q_W + CNT_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);

    state_e           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [ACC_W-1:0] term_c;
    logic [ACC_W-1:0] acc_next_c;
    logic [ACC_W-1:0] bias_ext_c;
    logic [Q_W-1:0]   sat_c;
    logic             xfer_c;
    logic             last_c;

    assign xfer_c     = in_valid && in_ready;
    assign last_c     = (cnt == LAST_CNT);
    assign term_c     = v_bit ? ACC_W'(sext_q(weight)) : '0;
    assign bias_ext_c = ACC_W'(sext_q(bias));
    assign acc_next_c = acc + term_c;

    // Saturate the value that includes the beat being taken, so the last edge can register sum.
    sat16 #(
        .ACC_W (ACC_W)
    ) u_sat (
        .value (acc_next_c),
        .sat_c (sat_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= '0;
            sum       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc      <= bias_ext_c;
                        cnt      <= '0;
                        state    <= ST_ACCUM;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (xfer_c) begin
                        acc <= acc_next_c;
                        cnt <= cnt + 1'b1;
                        if (last_c) begin
                            state     <= ST_DONE;
                            sum       <= sat_c;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accum.sv
// Scoreboard bench for sum_accum with N_IN=4: expected sums are queued at start
// and compared when out_valid rises.
module tb_sum_accum;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic        v_bit;
    logic [15:0] weight;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    sum_accum #(.N_IN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .v_bit     (v_bit),
        .weight    (weight),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] b, input logic [3:0] vb,
                                          input logic [3:0][15:0] w);
        int a;
        a = int'($signed(b));
        for (int i = 0; i < 4; i++) begin
            if (vb[i]) a += int'($signed(w[i]));
        end
        if (a > 32767)  return 16'h7FFF;
        if (a < -32768) return 16'h8000;
        return 16'(a);
    endfunction

    // One complete sum; stall_at<4 inserts a 3-cycle in_valid gap before that beat.
    task automatic do_sum(input logic [15:0] b, input logic [3:0] vb, input logic [3:0][15:0] w,
                          input int stall_at, input int hold, input bit poke);
        logic [15:0] held;
        int cyc;
        int tmo;
        exp_q.push_back(model(b, vb, w));
        @(negedge clk);
        bias  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bias  = 16'hDEAD;
        cyc   = 1;
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i == stall_at) begin
                in_valid = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    start  = poke;
                    v_bit  = 1'b1;
                    weight = 16'h7FFF;
                    @(negedge clk);
                    cyc++;
                end
                start = 1'b0;
            end
            in_valid = 1'b1;
            v_bit    = vb[i];
            weight   = w[i];
            chk("in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        v_bit    = 1'b0;
        weight   = 16'h0000;
        tmo = 0;
        while (!out_valid && tmo < 20) begin
            @(negedge clk);
            cyc++;
            tmo++;
        end
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        chk("in_ready_done", 32'(in_ready), 32'd0);
        if (stall_at > 3) chk("latency", 32'(cyc), 32'd5);
        held = sum;
        if (exp_q.size() > 0) chk("sum", 32'(held), 32'(exp_q.pop_front()));
        else chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start     = poke;
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(sum), 32'(held));
        end
        start     = poke;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("sum_kept", 32'(sum), 32'(held));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        bias      = 16'h0000;
        in_valid  = 1'b0;
        v_bit     = 1'b0;
        weight    = 16'h0000;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        rst_n = 1'b1;

        do_sum(16'h0100, 4'b1111, {4{16'h0080}}, 4, 0, 1'b0);
        do_sum(16'h0000, 4'b0101, {16'h7FFF, 16'hFF00, 16'h7FFF, 16'h0200}, 4, 1, 1'b0);
        do_sum(16'h7000, 4'b1111, {4{16'h7000}}, 4, 0, 1'b0);
        do_sum(16'h9000, 4'b1111, {4{16'h9000}}, 4, 0, 1'b0);
        do_sum(16'h0040, 4'b1011, {16'h0100, 16'h1234, 16'hFFF0, 16'h0010}, 2, 5, 1'b1);
        do_sum(16'hFF80, 4'b1110, {16'h0040, 16'hFFC0, 16'h0020, 16'h7FFF}, 1, 2, 1'b1);

        // Abandon a sum with reset after two beats.
        @(negedge clk);
        bias  = 16'h0050;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        v_bit    = 1'b1;
        weight   = 16'h0100;
        repeat (2) @(negedge clk);
        chk("busy_before_rst", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_sum", 32'(sum), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_reset", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_release", 32'(busy), 32'd0);
        chk("no_partial_valid", 32'(out_valid), 32'd0);

        do_sum(16'h0010, 4'b1111, {4{16'h0001}}, 4, 0, 1'b0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_accum.md
SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 SHALL have parameter N_IN, default 16, the number of visible-unit/weight terms per sum (range 2..1024).
REQ-002 SHALL have parameter CNT_W, default $clog2(N_IN), the width of the term counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a new sum.
REQ-006 SHALL have port bias, input, 16, signed Q7.8 bias, sampled on an accepted start.
REQ-007 SHALL have port in_valid, input, 1, meaning a term beat is presented.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts a term beat.
REQ-009 SHALL have port v_bit, input, 1, the binary visible-unit state for the beat.
REQ-010 SHALL have port weight, input, 16, signed Q7.8 weight for the beat.
REQ-011 SHALL have port out_valid, output, 1, meaning sum holds a finished result.
REQ-012 SHALL have port out_ready, input, 1, meaning the downstream sigmoid stage takes the result.
REQ-013 SHALL have port sum, output, 16, signed Q7.8 saturated sum, the direct feed of the sigmoid stage.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, ACCUM and DONE.
REQ-016 In IDLE, start SHALL load acc with sign-extended bias and clear the counter, then move to ACCUM.
REQ-017 start SHALL be ignored in ACCUM and DONE, with no effect on acc, the counter or the state.
REQ-018 in_ready SHALL equal 1 exactly when the state is ACCUM.
REQ-019 A beat transfers when in_valid && in_ready.
REQ-020 On each transfer, acc SHALL add sign-extended weight if v_bit=1 and add 0 if v_bit=0, and the counter SHALL increment.
REQ-021 acc SHALL be ACC_W = 16+CNT_W+1 bits wide, so no internal overflow is possible for N_IN terms plus bias.
REQ-022 The transfer taken with counter = N_IN-1 SHALL be the last beat: the state goes to DONE and sum is registered in the same edge.
REQ-023 sum SHALL be saturated from acc: acc > 32767 gives 0x7FFF, acc < -32768 gives 0x8000, otherwise acc[15:0].
REQ-024 out_valid SHALL rise in the cycle after the last beat transfers and SHALL equal 1 exactly when the state is DONE.
REQ-025 sum SHALL hold stable while out_valid=1.
REQ-026 In DONE, out_ready=1 SHALL move the state to IDLE on that edge; sum SHALL keep its last value afterwards.
REQ-027 A start in the cycle the DONE-to-IDLE handshake completes SHALL be ignored; a new start is accepted from the next cycle.
REQ-028 Stalls (in_valid=0 in ACCUM) SHALL leave acc and the counter unchanged, with no timeout.
REQ-029 Throughput SHALL be one beat per cycle; total latency from start to out_valid is N_IN+1 cycles when there are no stalls.

Reset
REQ-030 When rst_n=0, the state SHALL go to IDLE asynchronously and acc, the counter and sum SHALL clear to 0.
REQ-031 Reset values SHALL be: in_ready=0, out_valid=0, busy=0, sum=0x0000.
REQ-032 Reset during ACCUM or DONE SHALL abandon the sum; no partial result is ever presented.
REQ-033 Reset release SHALL take effect at the next clk edge; the first start is accepted no earlier than the first edge with rst_n=1.

Structure
REQ-034 The Q7.8 width (16), the saturation limits 0x7FFF/0x8000 and the state encoding SHALL live in the shared config include used by the RBM blocks.
REQ-035 A sub-module sat16 SHALL be used: combinational, ACC_W-bit signed in, 16-bit saturated out.
REQ-036 All outputs SHALL be registered or decoded only from state, with no input-to-output combinational path.

Verification (bench N_IN=4)
REQ-037 Bench SHALL check: bias=0x0100, v=1,1,1,1, weights 0x0080 each -> sum=0x0300, out_valid at cycle 5 after start.
REQ-038 Bench SHALL check: bias=0x0000, v=1,0,1,0, weights 0x0200,0x7FFF,0xFF00,0x7FFF -> sum=0x0100 (v=0 terms ignored).
REQ-039 Bench SHALL check: bias=0x7000, v all 1, weights 0x7000 each -> sum=0x7FFF; and bias=0x9000, weights 0x9000 -> sum=0x8000.
REQ-040 Bench SHALL check: in_valid dropped for 3 cycles mid-sum, out_ready held 0 for 5 cycles, start pulsed during ACCUM/DONE -> result unchanged, sum stable, extra starts ignored.
REQ-041 Bench SHALL check: rst_n pulsed low after 2 beats -> outputs immediately at reset values; a fresh sum of bias=0x0010, weights 0x0001 x4 (v=1) -> sum=0x0014.
